// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencer: FSM state encoding and
// the prescaler width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  // Width of a counter that must hold 0..prescale-1 (never below 1 bit).
  function automatic int pre_width(input int prescale);
    return (prescale < 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/digit_cnt4.sv
// One 4-bit binary digit of the count chain. Synchronous clear has priority
// over the count enable; tc tells the next digit to advance.
module digit_cnt4 (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ce,
  input  logic       sclr,
  output logic [3:0] q,
  output logic       tc
);

  // Digit register: clear, else increment (wrapping F->0) on enable.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)     q <= 4'h0;
    else if (sclr) q <= 4'h0;
    else if (ce)   q <= q + 4'h1;
  end

  assign tc = ce && (q == 4'hF);

endmodule

// File: rtl/stopwatch_seq.sv
// Run/pause/clear sequencer driving a cascaded 4-bit count chain. Holds the
// command FSM, the clock prescaler and the sticky overflow flag.
module stopwatch_seq
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int DIGITS   = 2
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   count,
  output logic                  cnt_ce,
  output logic                  running,
  output logic                  overflow
);

  localparam int            PW      = pre_width(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_pre;
  logic [PW-1:0]   w_pre_nxt;
  logic            r_ovf;
  logic            w_sclr;
  logic [DIGITS:0] w_carry;

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; clr beats stop beats start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (clr)        w_state_nxt = S_CLEAR;
        else if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (clr)       w_state_nxt = S_CLEAR;
        else if (stop) w_state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (clr)        w_state_nxt = S_CLEAR;
        else if (start) w_state_nxt = S_RUN;
      end
      S_CLEAR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Prescaler next value: zeroed by CLEAR or a fresh start from IDLE,
  // advances only while running, holds otherwise (so PAUSE resumes mid-phase).
  always_comb begin
    w_pre_nxt = r_pre;
    if (r_state == S_CLEAR) begin
      w_pre_nxt = '0;
    end else if (r_state == S_IDLE && start && !clr) begin
      w_pre_nxt = '0;
    end else if (r_state == S_RUN) begin
      w_pre_nxt = (r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_pre <= '0;
    else       r_pre <= w_pre_nxt;
  end

  assign running = (r_state == S_RUN);
  assign cnt_ce  = running && (r_pre == PRE_MAX);
  assign w_sclr  = (r_state == S_CLEAR);

  // A coincident clr suppresses the increment; the chain is zeroed next cycle.
  assign w_carry[0] = cnt_ce && !clr;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    digit_cnt4 u_digit (
      .clk   (clk),
      .Reset (Reset),
      .ce    (w_carry[g]),
      .sclr  (w_sclr),
      .q     (count[4*g +: 4]),
      .tc    (w_carry[g+1])
    );
  end

  // Sticky overflow: set when the top digit carries out, cleared by CLEAR.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)                r_ovf <= 1'b0;
    else if (w_sclr)          r_ovf <= 1'b0;
    else if (w_carry[DIGITS]) r_ovf <= 1'b1;
  end

  assign overflow = r_ovf;

endmodule

// File: tb/tb_stopwatch_seq.sv
// Directed bench for stopwatch_seq with an abstract cycle model and a
// per-cycle compare, plus literal expectations at key points.
module tb_stopwatch_seq;

  localparam int P   = 4;
  localparam int D   = 2;
  localparam int MOD = 1 << (4 * D);

  logic         clk;
  logic         Reset;
  logic         start;
  logic         stop;
  logic         clr;
  logic [4*D-1:0] count;
  logic         cnt_ce;
  logic         running;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_seq #(.PRESCALE(P), .DIGITS(D)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .start    (start),
    .stop     (stop),
    .clr      (clr),
    .count    (count),
    .cnt_ce   (cnt_ce),
    .running  (running),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: counting/paused flags, a phase counter and the count
  // value, updated with the rules of each clock edge.
  int m_count    = 0;
  int m_pre      = 0;
  bit m_run      = 0;
  bit m_paused   = 0;
  bit m_clearing = 0;
  bit m_ovf      = 0;

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      m_count = 0; m_pre = 0; m_run = 0; m_paused = 0; m_clearing = 0; m_ovf = 0;
    end else if (m_clearing) begin
      m_count = 0; m_pre = 0; m_ovf = 0; m_clearing = 0;
    end else begin
      if (m_run) begin
        if (m_pre == P - 1 && !clr) begin
          if (m_count == MOD - 1) m_ovf = 1;
          m_count = (m_count + 1) % MOD;
        end
        m_pre = (m_pre + 1) % P;
      end
      if (clr) begin
        m_clearing = 1; m_run = 0; m_paused = 0;
      end else if (m_run) begin
        if (stop) begin m_run = 0; m_paused = 1; end
      end else if (start) begin
        if (!m_paused) m_pre = 0;
        m_run = 1; m_paused = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (Reset === 1'b0) begin
      check("count",    32'(count),    32'(m_count));
      check("running",  32'(running),  32'(m_run));
      check("cnt_ce",   32'(cnt_ce),   32'(m_run && (m_pre == P - 1)));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit s, input bit p, input bit c);
    start = s; stop = p; clr = c;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_ce(input int limit, input string name);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (cnt_ce === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_count(input logic [7:0] v, input int limit, input string name);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (count === v) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check(name, 32'(count), 32'(v));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;
    tick(3);
    check("rst_count",    32'(count),    32'h0);
    check("rst_running",  32'(running),  32'h0);
    check("rst_cnt_ce",   32'(cnt_ce),   32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    Reset = 1'b0;
    tick(2);

    // Start and first increments
    pulse(1, 0, 0);
    check("t1_running", 32'(running), 32'h1);
    tick(3);
    check("t1_pre_ce", 32'(cnt_ce), 32'h1);
    check("t1_cnt00",  32'(count),  32'h00);
    tick(1);
    check("t1_cnt01", 32'(count), 32'h01);
    tick(4);
    check("t1_cnt02", 32'(count), 32'h02);
    tick(4);
    check("t1_cnt03", 32'(count), 32'h03);

    // Pause mid-phase and resume with the remaining prescale
    tick(8);
    check("t2_cnt05", 32'(count), 32'h05);
    tick(1);
    pulse(0, 1, 0);
    check("t2_paused", 32'(running), 32'h0);
    tick(20);
    check("t2_hold", 32'(count), 32'h05);
    pulse(1, 0, 0);
    check("t2_resume", 32'(count), 32'h05);
    tick(1);
    check("t2_resume_ce", 32'(cnt_ce), 32'h1);
    tick(1);
    check("t2_cnt06", 32'(count), 32'h06);

    // Digit carry
    wait_count(8'h0F, 60, "t3_reach0F");
    wait_ce(8, "t3_ce0F");
    tick(1);
    check("t3_carry10", 32'(count), 32'h10);
    wait_count(8'h1F, 80, "t3_reach1F");
    wait_ce(8, "t3_ce1F");
    tick(1);
    check("t3_carry20", 32'(count), 32'h20);

    // Full wrap and overflow
    pulse(0, 0, 1);
    tick(1);
    check("t4_clr_cnt", 32'(count), 32'h00);
    pulse(1, 0, 0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      wait_ce(8, "t4_ce");
      n++;
      if (n == 256) break;
      tick(1);
    end
    check("t4_at_FF",  32'(count),    32'hFF);
    check("t4_no_ovf", 32'(overflow), 32'h0);
    tick(1);
    check("t4_wrap00", 32'(count),    32'h00);
    check("t4_ovf",    32'(overflow), 32'h1);
    tick(8);
    check("t4_cont02", 32'(count),    32'h02);
    check("t4_sticky", 32'(overflow), 32'h1);
    pulse(0, 0, 1);
    check("t4_clr_run", 32'(running), 32'h0);
    tick(1);
    check("t4_clr_cnt00", 32'(count),    32'h00);
    check("t4_clr_ovf",   32'(overflow), 32'h0);
    tick(6);
    check("t4_idle_cnt", 32'(count), 32'h00);

    // Coincident commands
    pulse(1, 0, 0);
    tick(2);
    pulse(1, 1, 1);
    check("t5_all_run", 32'(running), 32'h0);
    tick(1);
    check("t5_all_cnt", 32'(count), 32'h00);
    pulse(1, 0, 0);
    wait_ce(8, "t5_ce_stop");
    pulse(0, 1, 0);
    check("t5_stop_inc", 32'(count),   32'h01);
    check("t5_stop_run", 32'(running), 32'h0);
    tick(3);
    check("t5_stop_hold", 32'(count), 32'h01);
    pulse(1, 0, 0);
    wait_ce(8, "t5_ce_clr");
    pulse(0, 0, 1);
    check("t5_clr_noinc", 32'(count), 32'h01);
    tick(1);
    check("t5_clr_zero", 32'(count), 32'h00);

    // Asynchronous reset between edges
    pulse(1, 0, 0);
    tick(9);
    check("t6_pre_cnt", 32'(count), 32'h02);
    #2;
    Reset = 1'b1;
    #1;
    check("t6_async_cnt", 32'(count),    32'h0);
    check("t6_async_run", 32'(running),  32'h0);
    check("t6_async_ce",  32'(cnt_ce),   32'h0);
    check("t6_async_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    Reset = 1'b0;
    tick(10);
    check("t6_idle_cnt", 32'(count),   32'h0);
    check("t6_idle_run", 32'(running), 32'h0);
    pulse(1, 0, 0);
    check("t6_restart", 32'(running), 32'h1);
    tick(4);
    check("t6_cnt01", 32'(count), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
